// File: rtl/button_control.sv
// button_control
//   Debounces a raw push-button and derives the blinker mode controls.
//   A short press toggles o_speed and a long press toggles o_enable.
//   A debounced level and a one-cycle press pulse are also exported.
//
// Parameters
//   DEBOUNCE_CYCLES    stable synchronized cycles needed to accept a change
//   LONG_PRESS_CYCLES  debounced hold cycles that make a press "long" (>= 2)
//
// Ports
//   i_clock        system clock, all logic on posedge
//   i_reset        synchronous active-high reset
//   i_button       raw asynchronous button, active-high, bouncy
//   o_enable       enable to blinky, toggled by a long press (reset 1)
//   o_speed        speed select to blinky, 1 = fast, toggled by a short press (reset 1)
//   o_pressed      debounced button level
//   o_press_pulse  one-cycle pulse on a debounced rising edge
//
// Press FSM states
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | button released, hold counter cleared
//   ST_PRESSED | button held, counting toward the long-press threshold
//   ST_LONG    | long press already acted on, waiting for release
module button_control #(
  parameter int DEBOUNCE_CYCLES   = 25000,
  parameter int LONG_PRESS_CYCLES = 2500000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_button,
  output logic o_enable,
  output logic o_speed,
  output logic o_pressed,
  output logic o_press_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  // ---------------------------------------------------------------
  // Two-flop synchronizer
  // ---------------------------------------------------------------
  logic sync_meta;
  logic sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= i_button;
      sync      <= sync_meta;
    end
  end

  // ---------------------------------------------------------------
  // Debounce: count consecutive cycles where sync disagrees with the
  // accepted level; accept on the last count and clear.
  // ---------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic            db_differs;
  logic            db_accept;

  assign db_differs = (sync != o_pressed);
  assign db_accept  = db_differs && (db_cnt == DB_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      db_cnt        <= '0;
      o_pressed     <= 1'b0;
      o_press_pulse <= 1'b0;
    end else begin
      // Pulse is registered alongside o_pressed so both rise together.
      o_press_pulse <= db_accept && sync;
      if (!db_differs || db_accept) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      if (db_accept) begin
        o_pressed <= sync;
      end
    end
  end

  // ---------------------------------------------------------------
  // Press classification FSM
  // ---------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              enable_nxt;
  logic              speed_nxt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      o_enable <= 1'b1;
      o_speed  <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      o_enable <= enable_nxt;
      o_speed  <= speed_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    enable_nxt = o_enable;
    speed_nxt  = o_speed;

    case (state)
      ST_IDLE: begin
        hold_nxt = '0;
        if (o_pressed) begin
          // The cycle that first sees the debounced press counts as the
          // first held cycle, so hold_cnt tracks cycles since o_pressed
          // rose and the long-press toggle lands LONG_PRESS_CYCLES after it.
          state_nxt = ST_PRESSED;
          hold_nxt  = HOLD_W'(1);
        end
      end

      ST_PRESSED: begin
        if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
        // Release is checked first so it wins over a coincident threshold.
        if (!o_pressed) begin
          speed_nxt = ~o_speed;
          state_nxt = ST_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          enable_nxt = ~o_enable;
          state_nxt  = ST_LONG;
        end
      end

      ST_LONG: begin
        if (!o_pressed) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_control.sv
// Directed testbench for button_control with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=20. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so "after edge N" below means
// the value registered on the Nth rising edge since the stimulus changed.
module tb_button_control;

  logic i_clock;
  logic i_reset;
  logic i_button;
  logic o_enable;
  logic o_speed;
  logic o_pressed;
  logic o_press_pulse;

  int vectors;
  int miscompares;

  button_control #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_button     (i_button),
    .o_enable     (o_enable),
    .o_speed      (o_speed),
    .o_pressed    (o_pressed),
    .o_press_pulse(o_press_pulse)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // 12-cycle press from IDLE: o_pressed spans edges 6..18, speed flips at 19.
  task automatic short_press(input logic speed_before, input logic enable_now);
    i_button = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("sp_pressed_early", o_pressed, 1'b0);
      chk("sp_pulse_early", o_press_pulse, 1'b0);
    end
    step();                                   // edge 6
    chk("sp_pressed_rise", o_pressed, 1'b1);
    chk("sp_pulse_rise", o_press_pulse, 1'b1);
    step();                                   // edge 7
    chk("sp_pulse_single", o_press_pulse, 1'b0);
    chk("sp_pressed_hold", o_pressed, 1'b1);
    repeat (5) step();                        // edge 12
    i_button = 1'b0;
    repeat (5) step();                        // edge 17
    chk("sp_pressed_before_fall", o_pressed, 1'b1);
    chk("sp_speed_before_fall", o_speed, speed_before);
    step();                                   // edge 18
    chk("sp_pressed_fall", o_pressed, 1'b0);
    chk("sp_speed_at_fall", o_speed, speed_before);
    step();                                   // edge 19
    chk("sp_speed_toggle", o_speed, ~speed_before);
    chk("sp_enable_kept", o_enable, enable_now);
    repeat (4) step();
    chk("sp_speed_stable", o_speed, ~speed_before);
    chk("sp_pulse_idle", o_press_pulse, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset     = 1'b1;
    i_button    = 1'b0;

    // ---- reset ----
    step();
    chk("rst_enable", o_enable, 1'b1);
    chk("rst_speed", o_speed, 1'b1);
    chk("rst_pressed", o_pressed, 1'b0);
    chk("rst_pulse", o_press_pulse, 1'b0);
    repeat (2) step();
    i_reset = 1'b0;
    repeat (3) step();

    // ---- bounce: 3-cycle glitches never reach the 4-cycle threshold ----
    for (int k = 0; k < 10; k++) begin
      i_button = (k % 2 == 0);
      repeat (3) begin
        step();
        chk("bounce_pressed", o_pressed, 1'b0);
        chk("bounce_pulse", o_press_pulse, 1'b0);
      end
    end
    i_button = 1'b0;
    repeat (8) step();
    chk("bounce_pressed_end", o_pressed, 1'b0);
    chk("bounce_speed", o_speed, 1'b1);
    chk("bounce_enable", o_enable, 1'b1);

    // ---- two short presses: speed 1 -> 0 -> 1 ----
    short_press(1'b1, 1'b1);
    short_press(1'b0, 1'b1);

    // ---- long press, 40 cycles: enable flips 20 cycles after o_pressed ----
    i_button = 1'b1;
    repeat (6) step();                        // edge 6
    chk("lp_pressed_rise", o_pressed, 1'b1);
    repeat (19) step();                       // edge 25
    chk("lp_enable_before", o_enable, 1'b1);
    step();                                   // edge 26
    chk("lp_enable_toggle", o_enable, 1'b0);
    repeat (14) step();                       // edge 40
    chk("lp_enable_once", o_enable, 1'b0);
    i_button = 1'b0;
    repeat (6) step();                        // edge 46
    chk("lp_pressed_fall", o_pressed, 1'b0);
    repeat (2) step();                        // edge 48
    chk("lp_speed_kept", o_speed, 1'b1);
    chk("lp_enable_kept", o_enable, 1'b0);
    repeat (4) step();

    // ---- boundary: release seen exactly when hold counter is 19 ----
    i_button = 1'b1;
    repeat (19) step();                       // edge 19
    i_button = 1'b0;
    repeat (6) step();                        // edge 25
    chk("bd_pressed_fall", o_pressed, 1'b0);
    chk("bd_speed_before", o_speed, 1'b1);
    step();                                   // edge 26
    chk("bd_speed_toggle", o_speed, 1'b0);
    chk("bd_enable_kept", o_enable, 1'b0);
    repeat (4) step();
    chk("bd_enable_stable", o_enable, 1'b0);
    chk("bd_speed_stable", o_speed, 1'b0);

    // ---- one cycle longer: threshold reached while still held ----
    i_button = 1'b1;
    repeat (20) step();                       // edge 20
    i_button = 1'b0;
    repeat (5) step();                        // edge 25
    chk("th_pressed_held", o_pressed, 1'b1);
    chk("th_enable_before", o_enable, 1'b0);
    step();                                   // edge 26
    chk("th_enable_toggle", o_enable, 1'b1);
    chk("th_pressed_fall", o_pressed, 1'b0);
    repeat (3) step();
    chk("th_speed_kept", o_speed, 1'b0);
    chk("th_enable_stable", o_enable, 1'b1);

    // ---- reset mid-press, released as reset drops: no toggle ----
    i_button = 1'b1;
    repeat (10) step();
    chk("rma_pressed", o_pressed, 1'b1);
    i_reset = 1'b1;
    step();
    chk("rma_pressed_rst", o_pressed, 1'b0);
    chk("rma_pulse_rst", o_press_pulse, 1'b0);
    chk("rma_speed_rst", o_speed, 1'b1);
    chk("rma_enable_rst", o_enable, 1'b1);
    step();
    i_reset  = 1'b0;
    i_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rma_pulse_after", o_press_pulse, 1'b0);
    end
    chk("rma_speed_after", o_speed, 1'b1);
    chk("rma_enable_after", o_enable, 1'b1);
    chk("rma_pressed_after", o_pressed, 1'b0);

    // ---- reset mid-press, held through reset: new press afterwards ----
    i_button = 1'b1;
    repeat (10) step();
    i_reset = 1'b1;
    step();
    chk("rmb_pressed_rst", o_pressed, 1'b0);
    step();
    i_reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("rmb_pulse_early", o_press_pulse, 1'b0);
    end
    step();                                   // 6 cycles after reset drops
    chk("rmb_pulse", o_press_pulse, 1'b1);
    chk("rmb_pressed", o_pressed, 1'b1);
    step();
    chk("rmb_pulse_single", o_press_pulse, 1'b0);
    step();                                   // R+8
    i_button = 1'b0;
    repeat (6) step();                        // R+14
    chk("rmb_pressed_fall", o_pressed, 1'b0);
    chk("rmb_speed_before", o_speed, 1'b1);
    step();                                   // R+15
    chk("rmb_speed_toggle", o_speed, 1'b0);
    chk("rmb_enable_kept", o_enable, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
